// File: rtl/mod_mul_barrett.sv
// ---------------------------------------------------------------------------
// mod_mul_barrett
//
// Five-stage pipelined Barrett modular multiplier, C = (A*B) mod q. It feeds
// the NTT butterfly subtractor with the twiddle product W*B. A valid bit
// travels with each operation. A single clock-enable stalls the pipeline.
//
// Parameter
//   K          bit length of q (2..48), 2^(K-1) <= q < 2^K
//
// Ports
//   clk        rising-edge clock
//   rstn       synchronous active-low reset, overrides ce
//   ce         pipeline enable; low freezes every register
//   in_valid   A/B/q/mu qualify this cycle
//   A, B       operands (< q), 48 bits, only [K-1:0] used
//   q          modulus, sampled per operation
//   mu         Barrett constant floor(2^(2K)/q), [K:0] used
//   out_valid  C holds a fresh result
//   C          (A*B) mod q, zero-extended above K bits, driven from a flop
// ---------------------------------------------------------------------------
module mod_mul_barrett #(
  parameter int K = 48
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ce,
  input  logic        in_valid,
  input  logic [47:0] A,
  input  logic [47:0] B,
  input  logic [47:0] q,
  input  logic [48:0] mu,
  output logic        out_valid,
  output logic [47:0] C
);

  localparam int PW = 2 * K;      // full product A*B
  localparam int UW = 2 * K + 2;  // t*mu, both K+1 bits
  localparam int QW = K + 1;      // quotient estimate / t / mu
  localparam int RW = K + 2;      // remainder domain, R < 3q < 2^(K+2)

  // S1: registered inputs
  logic [K-1:0]  a_s1_q, b_s1_q, m_s1_q;
  logic [QW-1:0] mu_s1_q;
  logic          v_s1_q;
  // S2: full product
  logic [PW-1:0] p_s2_q, p_d;
  logic [K-1:0]  m_s2_q;
  logic [QW-1:0] mu_s2_q;
  logic          v_s2_q;
  // S3: quotient estimate and low product bits
  logic [QW-1:0] qh_s3_q, qh_d;
  logic [RW-1:0] plo_s3_q;
  logic [K-1:0]  m_s3_q;
  logic          v_s3_q;
  // S4: partially reduced remainder
  logic [RW-1:0] r_s4_q, r_d;
  logic [K-1:0]  m_s4_q;
  logic          v_s4_q;
  // S5: final result
  logic [K-1:0]  c_q, c_d;
  logic          out_valid_q;

  logic [QW-1:0] t;
  logic [RW-1:0] qhq;
  logic [RW-1:0] two_q;
  logic [RW-1:0] q_ext;

  always_comb begin
    // NOTE: every combinational output is assigned before any branch so
    // no path through this block leaves a value unassigned (no latches).
    c_d   = r_s4_q[K-1:0];

    p_d   = PW'(a_s1_q) * PW'(b_s1_q);

    // Only the top K+1 bits of P enter the estimate; the product with mu is
    // shifted down by K+1, so only the quotient bits are kept.
    t     = p_s2_q[PW-1:K-1];
    qh_d  = QW'((UW'(t) * UW'(mu_s2_q)) >> (K + 1));

    // The true remainder is below 2^(K+2), so the subtraction only needs the
    // low K+2 bits of P and of qh*q; wraparound cancels.
    qhq   = RW'(qh_s3_q) * RW'(m_s3_q);
    r_d   = plo_s3_q - qhq;

    // qh underestimates the quotient by at most 2, so at most two
    // corrections are needed.
    two_q = RW'({m_s4_q, 1'b0});
    q_ext = RW'(m_s4_q);
    if (r_s4_q >= two_q) begin
      c_d = K'(r_s4_q - two_q);
    end else if (r_s4_q >= q_ext) begin
      c_d = K'(r_s4_q - q_ext);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every stage samples the previous
    // stage's value from before this edge, independent of statement order.
    if (!rstn) begin
      a_s1_q      <= '0;
      b_s1_q      <= '0;
      m_s1_q      <= '0;
      mu_s1_q     <= '0;
      v_s1_q      <= 1'b0;
      p_s2_q      <= '0;
      m_s2_q      <= '0;
      mu_s2_q     <= '0;
      v_s2_q      <= 1'b0;
      qh_s3_q     <= '0;
      plo_s3_q    <= '0;
      m_s3_q      <= '0;
      v_s3_q      <= 1'b0;
      r_s4_q      <= '0;
      m_s4_q      <= '0;
      v_s4_q      <= 1'b0;
      c_q         <= '0;
      out_valid_q <= 1'b0;
    end else if (ce) begin
      a_s1_q      <= A[K-1:0];
      b_s1_q      <= B[K-1:0];
      m_s1_q      <= q[K-1:0];
      mu_s1_q     <= mu[K:0];
      v_s1_q      <= in_valid;

      p_s2_q      <= p_d;
      m_s2_q      <= m_s1_q;
      mu_s2_q     <= mu_s1_q;
      v_s2_q      <= v_s1_q;

      qh_s3_q     <= qh_d;
      plo_s3_q    <= p_s2_q[RW-1:0];
      m_s3_q      <= m_s2_q;
      v_s3_q      <= v_s2_q;

      r_s4_q      <= r_d;
      m_s4_q      <= m_s3_q;
      v_s4_q      <= v_s3_q;

      // C only moves on a valid slot; bubbles leave the last result visible.
      if (v_s4_q) begin
        c_q <= c_d;
      end
      out_valid_q <= v_s4_q;
    end
  end

  assign out_valid = out_valid_q;
  assign C         = 48'(c_q);

endmodule

// File: tb/tb_mod_mul_barrett.sv
// ---------------------------------------------------------------------------
// tb_mod_mul_barrett
//
// Two instances: K=14 (q=12289) and K=48 (q=2^48-59). Expected results are
// pushed to a scoreboard queue when an operation is accepted, tagged with the
// enabled-edge count at which it must appear, and popped when the DUT shows
// out_valid. Stalled cycles check that outputs are frozen; bubble cycles check
// that C keeps the last result.
// ---------------------------------------------------------------------------
module tb_mod_mul_barrett;

  localparam logic [47:0] Q14  = 48'd12289;
  localparam logic [48:0] MU14 = 49'd21843;
  localparam logic [47:0] Q48  = 48'hFFFF_FFFF_FFC5;
  localparam logic [48:0] MU48 = 49'h1_0000_0000_003B;

  typedef struct {
    int          dut;
    logic [47:0] c;
    int          due;
  } exp_t;

  logic        clk;
  logic        rstn;
  logic        ce       [2];
  logic        in_valid [2];
  logic [47:0] a_in     [2];
  logic [47:0] b_in     [2];
  logic [47:0] q_in     [2];
  logic [48:0] mu_in    [2];
  logic        out_valid[2];
  logic [47:0] c_out    [2];

  logic [47:0] exp_c    [2];
  int          en_cnt   [2];
  logic        en_last  [2];
  logic        prev_v   [2];
  logic [47:0] prev_c   [2];
  logic [47:0] last_c   [2];
  logic        mon_ev;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  mod_mul_barrett #(.K(14)) u_dut14 (
    .clk(clk), .rstn(rstn), .ce(ce[0]), .in_valid(in_valid[0]),
    .A(a_in[0]), .B(b_in[0]), .q(q_in[0]), .mu(mu_in[0]),
    .out_valid(out_valid[0]), .C(c_out[0])
  );

  mod_mul_barrett #(.K(48)) u_dut48 (
    .clk(clk), .rstn(rstn), .ce(ce[1]), .in_valid(in_valid[1]),
    .A(a_in[1]), .B(b_in[1]), .q(q_in[1]), .mu(mu_in[1]),
    .out_valid(out_valid[1]), .C(c_out[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [47:0] ref_mod(input logic [47:0] a, input logic [47:0] b,
                                          input logic [47:0] m);
    logic [95:0] p;
    p = 96'(a) * 96'(b);
    return 48'(p % 96'(m));
  endfunction

  function automatic logic [47:0] rnd_below(input logic [47:0] m);
    logic [63:0] r;
    r = {$urandom, $urandom};
    return 48'(r % 64'(m));
  endfunction

  task automatic drive(input int d, input logic v, input logic [47:0] av,
                       input logic [47:0] bv, input logic [47:0] mv,
                       input logic [48:0] muv, input logic [47:0] ev);
    @(negedge clk);
    in_valid[d] = v;
    a_in[d]     = av;
    b_in[d]     = bv;
    q_in[d]     = mv;
    mu_in[d]    = muv;
    exp_c[d]    = ev;
  endtask

  task automatic idle(input int d);
    drive(d, 1'b0, 48'd0, 48'd0, (d == 0) ? Q14 : Q48, (d == 0) ? MU14 : MU48, 48'd0);
  endtask

  task automatic drain();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0;
      ce[d]       = 1'b1;
    end
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // Bookkeeping at the edge, output checks 1 time unit later.
  always begin
    @(posedge clk);
    if (!rstn) begin
      sb.delete();
      for (int d = 0; d < 2; d++) begin
        last_c[d]  = 48'd0;
        en_last[d] = 1'b1;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (ce[d]) begin
          en_cnt[d]++;
          en_last[d] = 1'b1;
          if (in_valid[d]) sb.push_back('{dut: d, c: exp_c[d], due: en_cnt[d] + 4});
        end else begin
          en_last[d] = 1'b0;
        end
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      if (!en_last[d]) begin
        check($sformatf("stall_ov%0d", d), 64'(out_valid[d]), 64'(prev_v[d]));
        check($sformatf("stall_c%0d", d), 64'(c_out[d]), 64'(prev_c[d]));
      end else begin
        mon_ev = (sb.size() != 0) && (sb[0].dut == d) && (sb[0].due == en_cnt[d]);
        check($sformatf("ov%0d", d), 64'(out_valid[d]), 64'(mon_ev));
        if (mon_ev) begin
          check($sformatf("c%0d", d), 64'(c_out[d]), 64'(sb[0].c));
          last_c[d] = sb[0].c;
          void'(sb.pop_front());
        end else begin
          check($sformatf("hold_c%0d", d), 64'(c_out[d]), 64'(last_c[d]));
        end
      end
      prev_v[d] = out_valid[d];
      prev_c[d] = c_out[d];
    end
  end

  logic [47:0] dir_a [4] = '{48'd12288, 48'd0,   48'd1,    48'd2};
  logic [47:0] dir_b [4] = '{48'd12288, 48'd777, 48'd5000, 48'd7000};
  logic [47:0] dir_c [4] = '{48'd1,     48'd0,   48'd5000, 48'd1711};
  logic        bub   [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    logic [47:0] ra, rb;
    rstn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      ce[d] = 1'b1; in_valid[d] = 1'b0; a_in[d] = '0; b_in[d] = '0;
      q_in[d] = (d == 0) ? Q14 : Q48; mu_in[d] = (d == 0) ? MU14 : MU48;
      exp_c[d] = '0; en_cnt[d] = 0; en_last[d] = 1'b1;
      prev_v[d] = 1'b0; prev_c[d] = '0; last_c[d] = '0;
    end

    // Reset held for 3 edges with valid traffic present: nothing may leak.
    in_valid[0] = 1'b1; a_in[0] = rnd_below(Q14); b_in[0] = rnd_below(Q14);
    repeat (2) drive(0, 1'b1, rnd_below(Q14), rnd_below(Q14), Q14, MU14, 48'd0);
    idle(0);
    rstn = 1'b1;
    repeat (6) idle(0);

    // Directed K=14 back-to-back stream.
    for (int i = 0; i < 4; i++) drive(0, 1'b1, dir_a[i], dir_b[i], Q14, MU14, dir_c[i]);
    drain();

    // Bubbles: C must hold on invalid slots.
    for (int i = 0; i < 5; i++) begin
      ra = rnd_below(Q14); rb = rnd_below(Q14);
      drive(0, bub[i], ra, rb, Q14, MU14, ref_mod(ra, rb, Q14));
    end
    drain();

    // Stall: ce low for 3 cycles after the 2nd op, junk offered meanwhile.
    for (int i = 0; i < 4; i++) begin
      ra = rnd_below(Q14); rb = rnd_below(Q14);
      drive(0, 1'b1, ra, rb, Q14, MU14, ref_mod(ra, rb, Q14));
      ce[0] = 1'b1;
      if (i == 1) begin
        for (int s = 0; s < 3; s++) begin
          drive(0, 1'b1, rnd_below(Q14), rnd_below(Q14), Q14, MU14, 48'd0);
          ce[0] = 1'b0;
        end
      end
    end
    drain();

    // Reset mid-flight: three ops in flight are discarded.
    drive(0, 1'b1, 48'd100, 48'd200, Q14, MU14, 48'd0);
    drive(0, 1'b1, 48'd300, 48'd400, Q14, MU14, 48'd0);
    drive(0, 1'b1, 48'd500, 48'd600, Q14, MU14, 48'd0);
    rstn = 1'b0;
    idle(0);
    rstn = 1'b1;
    repeat (6) idle(0);
    drive(0, 1'b1, 48'd12000, 48'd11111, Q14, MU14, ref_mod(48'd12000, 48'd11111, Q14));
    drain();

    // K=14 random with random ce and in_valid.
    for (int i = 0; i < 300; i++) begin
      ra = rnd_below(Q14); rb = rnd_below(Q14);
      drive(0, ($urandom_range(0, 3) != 0), ra, rb, Q14, MU14, ref_mod(ra, rb, Q14));
      ce[0] = ($urandom_range(0, 9) != 0);
    end
    drain();

    // K=48 directed corner cases.
    drive(1, 1'b1, Q48 - 48'd1, Q48 - 48'd1, Q48, MU48, 48'd1);
    drive(1, 1'b1, 48'h8000_0000_0000, 48'd2, Q48, MU48, 48'd59);
    drain();

    // K=48 random with random ce and in_valid.
    for (int i = 0; i < 1500; i++) begin
      ra = rnd_below(Q48); rb = rnd_below(Q48);
      drive(1, ($urandom_range(0, 4) != 0), ra, rb, Q48, MU48, ref_mod(ra, rb, Q48));
      ce[1] = ($urandom_range(0, 9) != 0);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
